// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor D = A - B, LSB first, one
//               full-subtractor cell with a registered borrow.
//               Optional macro SERIAL_SUB_SAT_EN saturates D to 0 on borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int             c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_done;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_d_final;

  // Single full-subtractor cell acting on the current LSBs
  assign w_a      = r_sa[0];
  assign w_b      = r_sb[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_sr_nxt = {w_d, r_sr[WIDTH-1:1]};
  assign w_last   = (r_cnt == c_LAST);

`ifdef SERIAL_SUB_SAT_EN
  assign w_d_final = w_br_nxt ? '0 : w_sr_nxt;
`else
  assign w_d_final = w_sr_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_sa  <= A;
            r_sb  <= B;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Final bit: publish the result including this cycle's difference bit
          if (w_last) begin
            r_d    <= w_d_final;
            r_bout <= w_br_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (r_state == S_RUN);
  assign DONE = r_done;
  assign D    = r_d;
  assign BOUT = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (WIDTH=8) using
//               directed vectors; honours SERIAL_SUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] D;
  logic       BOUT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_count    = 0;
  int last_done_cyc = 0;
  logic [8:0] sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
    .BOUT  (BOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [8:0] expv(input logic [7:0] wrap, input logic bo);
    expv = {bo, (c_SAT && bo) ? 8'd0 : wrap};
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every DONE pops one expected result
  always @(negedge CLK) begin
    if (!RST && DONE === 1'b1) begin
      logic [8:0] e;
      done_count++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got D=%0d BOUT=%0d, expected no DONE", D, BOUT);
      end else begin
        e = sb.pop_front();
        check("result_D", int'(D), int'(e[7:0]));
        check("result_BOUT", int'(BOUT), int'(e[8]));
      end
      check("busy_low_with_done", int'(BUSY), 0);
    end
  end

  task automatic wait_done(input int target, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      #1;
      if (done_count >= target) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got done_count=%0d, expected %0d", name, done_count, target);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] wrap, input logic bo);
    int acc;
    int prev;
    logic [8:0] e;
    e = expv(wrap, bo);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    START = 1'b0;
    A = ~a; B = ~b;
    prev = done_count;
    sb.push_back(e);
    check("busy_after_accept", int'(BUSY), 1);
    wait_done(prev + 1, "op");
    check("latency", last_done_cyc - acc, 8);
    repeat (3) @(negedge CLK);
    check("d_holds", int'(D), int'(e[7:0]));
  endtask

  initial begin
    int acc;
    int prev;
    int d1;
    RST = 1'b1; START = 1'b0; A = 8'd0; B = 8'd0;
    repeat (2) @(negedge CLK);
    check("rst_BUSY", int'(BUSY), 0);
    check("rst_DONE", int'(DONE), 0);
    check("rst_D", int'(D), 0);
    check("rst_BOUT", int'(BOUT), 0);
    RST = 1'b0;

    run_op(8'd5,   8'd3,   8'd2,   1'b0);
    run_op(8'd3,   8'd5,   8'd254, 1'b1);
    run_op(8'd0,   8'd0,   8'd0,   1'b0);
    run_op(8'd255, 8'd255, 8'd0,   1'b0);
    run_op(8'd0,   8'd1,   8'd255, 1'b1);

    // START held: two back-to-back operations
    @(negedge CLK);
    A = 8'd200; B = 8'd100; START = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    A = 8'd10; B = 8'd20;
    prev = done_count;
    sb.push_back(expv(8'd100, 1'b0));
    sb.push_back(expv(8'd246, 1'b1));
    wait_done(prev + 1, "b2b_first");
    d1 = last_done_cyc;
    check("b2b_latency", d1 - acc, 8);
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("b2b_second_accepted", int'(BUSY), 1);
    wait_done(prev + 2, "b2b_second");
    check("b2b_done_spacing", last_done_cyc - d1, 9);

    // START while busy is ignored
    @(negedge CLK);
    A = 8'd100; B = 8'd1; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    prev = done_count;
    sb.push_back(expv(8'd99, 1'b0));
    repeat (3) @(negedge CLK);
    A = 8'd1; B = 8'd2; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(prev + 1, "busy_ignore");
    repeat (12) @(negedge CLK);
    check("busy_ignore_one_done", done_count - prev, 1);

    // Asynchronous reset mid-operation
    @(negedge CLK);
    A = 8'd50; B = 8'd20; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    prev = done_count;
    repeat (4) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("arst_BUSY", int'(BUSY), 0);
    check("arst_DONE", int'(DONE), 0);
    check("arst_D", int'(D), 0);
    check("arst_BOUT", int'(BOUT), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (15) @(negedge CLK);
    check("arst_no_done", done_count - prev, 0);

    run_op(8'd9, 8'd4, 8'd5, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing D = A − B over WIDTH clock cycles, LSB first, with a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the team's combinational adder cells. It sits beside the adder library for area-constrained datapaths that can tolerate multi-cycle latency. A START/BUSY/DONE handshake lets a controller launch one operation at a time and collect the result.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range is 2 to 32.
- CLK, input, 1: the only clock; all state updates on the rising edge.
- RST, input, 1: asynchronous, active-high reset.
- START, input, 1: request to launch an operation; sampled only while idle.
- A, input, WIDTH: minuend; sampled on the edge that accepts START.
- B, input, WIDTH: subtrahend; sampled on the edge that accepts START.
- BUSY, output, 1: high while an operation is in progress.
- DONE, output, 1: single-cycle pulse when D and BOUT are updated.
- D, output, WIDTH: difference (A − B) mod 2^WIDTH, or the saturated value when that option is enabled; holds until the next completion.
- BOUT, output, 1: final borrow; 1 when A < B. Holds with D.

## Operation
- States: IDLE and RUN.
- IDLE:
  - START=1 loads A into shift register SA, B into SB, clears the borrow register BR, the bit counter CNT, and the result shift register SR.
  - Sets BUSY=1 and moves to RUN.
- RUN, once per cycle:
  - Take a=SA[0] and b=SB[0].
  - Compute d = a ^ b ^ BR.
  - Compute the next borrow: BR ← (~a & b) | (~(a ^ b) & BR).
  - Shift SA and SB right by 1.
  - Shift d into SR from the MSB side, so SR ← {d, SR[WIDTH-1:1]}.
  - Increment CNT.
- Completion, on the RUN cycle where CNT == WIDTH−1:
  - Load D with the final SR value, including the current d.
  - Load BOUT with the final borrow.
  - Assert DONE for one cycle, drop BUSY, and return to IDLE.
- START while BUSY=1 is ignored. A and B may change freely after acceptance.
- The internal shift registers, BR and CNT are not visible at the outputs. D and BOUT change only on completion.
- Reset at any time aborts an operation in progress: state goes to IDLE and every register clears.

## Timing
- Reset values:
  - BUSY=0, DONE=0, D=0, BOUT=0.
  - State IDLE; CNT, BR, SA, SB and SR all 0.
- START is accepted at edge E0, and BUSY is high from E0.
- Bits 0 through WIDTH−1 are processed at edges E1 through E_WIDTH.
- At edge E_WIDTH: D and BOUT update, DONE rises, BUSY falls.
- At edge E_WIDTH+1: DONE falls.
- Latency from the accepting edge to DONE is WIDTH cycles.
- Throughput: a new START may be accepted at the edge that deasserts DONE (E_WIDTH+1). Back-to-back operations therefore repeat every WIDTH+1 cycles.
- BUSY and DONE are never high in the same cycle.
- If START=1 is held continuously, a new operation is accepted on every IDLE cycle.
- RST assertion clears all outputs asynchronously and does not wait for CLK. The first START is accepted at the first rising edge after RST is deasserted.

## Configuration
- SERIAL_SUB_SAT_EN:
  - Defined: on completion with a final borrow of 1, D is forced to 0 (saturating unsigned subtract). BOUT still reports 1.
  - Undefined: D is the wrap-around two's-complement difference (A − B) mod 2^WIDTH.
- The macro does not change latency, handshake or reset behaviour.

## Test plan
- WIDTH=8, A=5, B=3, pulse START → DONE exactly 8 cycles after the accepting edge, with D=2 and BOUT=0.
- A=3, B=5 → BOUT=1. D=254 without SERIAL_SUB_SAT_EN; D=0 with SERIAL_SUB_SAT_EN.
- Edge cases, each checking the borrow chain across all bits:
  - A=0, B=0 → D=0, BOUT=0.
  - A=255, B=255 → D=0, BOUT=0.
  - A=0, B=1 → D=255 (or 0 with SERIAL_SUB_SAT_EN), BOUT=1.
- START held high with operand pairs (200,100) then (10,20) → results D=100/BOUT=0, then D=246/BOUT=1. DONE pulses are 9 cycles apart.
- START pulsed while BUSY, with different operands → ignored; the result matches the first operands, and only one DONE pulse occurs.
- RST asserted 4 cycles into an operation → BUSY, DONE, D and BOUT go to 0 immediately with no DONE pulse. A following START with A=9, B=4 completes normally with D=5.
